rom_writer: RTL and testbench
=============================

# rom_writer

Consumes the byte stream `iosys` produces during ROM loading (`rom_loading`, `rom_do`, `rom_do_valid`). It packs the bytes little-endian into 16-bit words, buffers them, and issues SDRAM word writes through a busy-gated port. It sits between `iosys` and the SDRAM arbiter's ROM-load port. It also reports completion, byte count and error flags back to the top level.

## Interface
Parameters:
- `BASE_ADDR`, 23'h000000: SDRAM byte address of ROM byte 0; must be even.
- `FIFO_DEPTH`, 8: word FIFO entries; power of 2, at least 4.

Ports:
- `wclk`  in  1  system clock; the only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `rom_loading`  in  1  level from iosys; a rising edge starts a load, a falling edge ends it.
- `rom_do`  in  8  ROM data byte.
- `rom_do_valid`  in  1  one-cycle strobe; `rom_do` is valid in that cycle.
- `rom_mask`  in  24  ROM size minus 1; stable before the first data byte.
- `ram_addr`  out  23  SDRAM byte address; always even.
- `ram_din`  out  16  write data.
- `ram_ds`  out  2  byte enables; bit0 = [7:0].
- `ram_wr`  out  1  write request; held until accepted.
- `ram_busy`  in  1  arbiter busy; a write is accepted in a cycle where `ram_wr`=1 and `ram_busy`=0.
- `load_done`  out  1  one-cycle pulse when the load is fully written.
- `byte_count`  out  24  bytes accepted in the current or last load.
- `overflow`  out  1  sticky: a word arrived while the FIFO was full.
- `oversize`  out  1  sticky: a byte arrived with index > `rom_mask`.

## Operation
- Reset values: all outputs 0; `ram_ds`=2'b11. Internal FSM goes to IDLE; FIFO empty; pair register empty.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: a `rom_loading` rising edge moves to LOAD. Same-cycle entry clears `byte_count`, `overflow`, `oversize`, the FIFO, the pair register and the write address.
  - LOAD: accepts bytes. A `rom_loading` falling edge moves to FLUSH.
  - FLUSH: if a lone low byte is pending, push it as a word with ds=2'b01 and high byte 0. Stay until the FIFO is empty and no write is outstanding, then go to DONE.
  - DONE: pulse `load_done` for one cycle, then go to IDLE.
- A `rom_loading` rising edge in any state aborts the current load. The pending write is dropped, and the state restarts LOAD with everything cleared.
- Byte handling on `rom_do_valid` in LOAD:
  - If `byte_count` > `rom_mask`: drop the byte, set `oversize`, do not increment the count.
  - Otherwise, on an even count, store the byte as the low byte.
  - On an odd count, form {`rom_do`, low} and push with ds=2'b11.
  - Increment `byte_count` for every accepted byte.
- Word address = `BASE_ADDR` + (index of the word's low byte). It is computed when the word is pushed and stored in the FIFO entry alongside data and ds (41 bits per entry). Arithmetic is mod 2^23.
- Push when the FIFO is full: drop the word, set `overflow`, keep counting.
- `rom_do_valid` outside LOAD is ignored.
- An async reset mid-load abandons everything; the SDRAM contents are then undefined.

## Timing
- All outputs are registered.
- Byte with odd index accepted in cycle N: the word is in the FIFO at the end of N. If the FIFO was empty and the port idle, `ram_wr`/`ram_addr`/`ram_din`/`ram_ds` are valid from N+1.
- Back-to-back accepts are possible. After acceptance in cycle M, the next FIFO head is presented at M+1; `ram_wr` stays 1 if the FIFO is non-empty.
- FIFO push and pop in the same cycle when full is legal and counts as not full; no overflow is flagged.
- `load_done` fires at least 2 cycles after the `rom_loading` falling edge, and after the last accept.
- Sustained input rate is 4 bytes per iosys store (4 consecutive cycles). With `ram_busy` low, 2 words are drained per 4 cycles, so the FIFO never fills.

## Structure
- `rom_writer_pkg`: FSM state enum; the FIFO entry layout widths (23 + 16 + 2); the reset value of `ram_ds`.
- Sub-module `word_fifo`: a synchronous, show-ahead FIFO.
  - Parameterised width and depth.
  - Ports: push, pop, full, empty, async clear.
  - Clocked by `wclk`, reset by `resetn`.

## Test plan
- Load 8 bytes 0x00..0x07, `ram_busy`=0, BASE=0: expect 4 writes at addresses 0,2,4,6 with data 0x0100, 0x0302, 0x0504, 0x0706, all ds=11. Then `load_done` pulses, `byte_count`=8.
- Load 5 bytes, then drop `rom_loading`: expect the last write at address 4 with data 0x00NN and ds=01, then `load_done`.
- `rom_mask`=3 and 6 bytes sent: expect 2 writes, `oversize`=1, `byte_count`=4.
- `ram_busy` held high for 40 cycles while 40 bytes arrive: expect `overflow`=1 after the 9th word, with writes resuming in order once busy drops.
- Assert `resetn`=0 mid-load with `ram_wr`=1: all outputs are immediately at their reset values, and the next load starts clean at BASE.
- Re-raise `rom_loading` during FLUSH: the pending word is discarded, no `load_done` pulse occurs, and the new load writes from BASE.

Source files
------------

// File: rtl/rom_writer_pkg.sv
// Shared types for the ROM loader: FSM states and the write-FIFO entry layout.
// The FIFO entry is laid out as {address, data, byte enables}.
package rom_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int DS_W    = 2;
  localparam int ENTRY_W = ADDR_W + DATA_W + DS_W;

  localparam logic [DS_W-1:0] DS_FULL      = 2'b11;
  localparam logic [DS_W-1:0] DS_LOW       = 2'b01;
  localparam logic [DS_W-1:0] RAM_DS_RESET = DS_FULL;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DS_W-1:0]   ds;
  } fifo_entry_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the oldest entry while not empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module word_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 8
) (
  input  logic             wclk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rom_writer.sv
// Packs the iosys ROM byte stream little-endian into 16-bit words and writes them
// to SDRAM through a busy-gated port, reporting byte count, errors and completion.
module rom_writer
  import rom_writer_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        wclk,
  input  logic        resetn,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  input  logic [23:0] rom_mask,
  output logic [22:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_ds,
  output logic        ram_wr,
  input  logic        ram_busy,
  output logic        load_done,
  output logic [23:0] byte_count,
  output logic        overflow,
  output logic        oversize,
  output logic [1:0]  fsm_state
);

  state_t      state;
  state_t      next_state;
  logic        loading_q;
  logic        rise;
  logic        fall;
  logic        byte_in;
  logic        byte_ok;
  logic        byte_drop;
  logic [7:0]  pair_low;
  logic        pair_valid;
  logic        flush_pair;
  logic        new_word_valid;
  fifo_entry_t new_word;
  fifo_entry_t fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        port_free;
  logic        bypass;
  logic        word_drop;
  logic        load_done_d;

  assign rise = rom_loading && !loading_q;
  assign fall = !rom_loading && loading_q;

  assign byte_in   = (state == ST_LOAD) && rom_do_valid && !rise;
  assign byte_ok   = byte_in && (byte_count <= rom_mask);
  assign byte_drop = byte_in && (byte_count > rom_mask);

  // A lone low byte is still pending on FLUSH entry when an odd count was accepted.
  assign flush_pair = (state == ST_FLUSH) && pair_valid && !rise;

  // The word's low byte index is the count with bit 0 cleared, in both push cases.
  always_comb begin
    new_word.addr  = BASE_ADDR + {byte_count[22:1], 1'b0};
    new_word.data  = {rom_do, pair_low};
    new_word.ds    = DS_FULL;
    new_word_valid = byte_ok && byte_count[0];
    if (flush_pair) begin
      new_word.data  = {8'h00, pair_low};
      new_word.ds    = DS_LOW;
      new_word_valid = 1'b1;
    end
  end

  // Write handshake: the port holds ram_wr/addr/din/ds stable until a cycle with
  // ram_wr=1 and ram_busy=0, which is the accept; the next word loads on that edge.
  // The output register is the first slot; an idle port takes a new word directly.
  assign port_free = !ram_wr || !ram_busy;
  assign fifo_pop  = !rise && port_free && !fifo_empty;
  assign bypass    = port_free && fifo_empty && new_word_valid;
  assign fifo_push = new_word_valid && !bypass;
  assign word_drop = fifo_push && fifo_full && !fifo_pop;

  word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk   (wclk),
    .resetn (resetn),
    .clear  (rise),
    .push   (fifo_push),
    .din    (new_word),
    .pop    (fifo_pop),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rise) begin
      next_state = ST_LOAD;
    end else begin
      unique case (state)
        ST_IDLE:  next_state = ST_IDLE;
        ST_LOAD:  if (fall) next_state = ST_FLUSH;
        ST_FLUSH: if (fifo_empty && !ram_wr && !pair_valid) next_state = ST_DONE;
        ST_DONE:  next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_done_d = (state == ST_FLUSH) && (next_state == ST_DONE);
    fsm_state   = state;
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      loading_q  <= 1'b0;
      byte_count <= '0;
      overflow   <= 1'b0;
      oversize   <= 1'b0;
      pair_low   <= '0;
      pair_valid <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      loading_q <= rom_loading;
      load_done <= load_done_d;
      if (rise) begin
        byte_count <= '0;
        overflow   <= 1'b0;
        oversize   <= 1'b0;
        pair_valid <= 1'b0;
      end else begin
        if (byte_ok) begin
          byte_count <= byte_count + 24'd1;
          if (!byte_count[0]) begin
            pair_low   <= rom_do;
            pair_valid <= 1'b1;
          end else begin
            pair_valid <= 1'b0;
          end
        end
        if (flush_pair) pair_valid <= 1'b0;
        if (byte_drop)  oversize   <= 1'b1;
        if (word_drop)  overflow   <= 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_ds   <= RAM_DS_RESET;
    end else if (rise) begin
      ram_wr <= 1'b0;
    end else if (port_free) begin
      if (!fifo_empty) begin
        ram_wr   <= 1'b1;
        ram_addr <= fifo_head.addr;
        ram_din  <= fifo_head.data;
        ram_ds   <= fifo_head.ds;
      end else if (new_word_valid) begin
        ram_wr   <= 1'b1;
        ram_addr <= new_word.addr;
        ram_din  <= new_word.data;
        ram_ds   <= new_word.ds;
      end else begin
        ram_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_writer.sv
// Bench for rom_writer: table-driven loads, hand-written corner sequences and
// randomized loads, all checked against expected SDRAM writes built from the byte stream.
module tb_rom_writer;
  import rom_writer_pkg::*;

  localparam logic [22:0] TB_BASE = 23'h004000;
  localparam int          DEPTH   = 8;

  logic        wclk;
  logic        resetn;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic [23:0] rom_mask;
  logic [22:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_ds;
  logic        ram_wr;
  logic        ram_busy;
  logic        load_done;
  logic [23:0] byte_count;
  logic        overflow;
  logic        oversize;
  logic [1:0]  fsm_state;

  rom_writer #(
    .BASE_ADDR  (TB_BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wclk         (wclk),
    .resetn       (resetn),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .rom_mask     (rom_mask),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_ds       (ram_ds),
    .ram_wr       (ram_wr),
    .ram_busy     (ram_busy),
    .load_done    (load_done),
    .byte_count   (byte_count),
    .overflow     (overflow),
    .oversize     (oversize),
    .fsm_state    (fsm_state)
  );

  typedef struct {
    int          n;
    logic [23:0] mask;
    logic [7:0]  dbase;
    logic [23:0] exp_count;
    logic        exp_ovs;
  } vec_t;

  int          vectors;
  int          miscompares;
  int          done_pulses;
  bit          busy_rand;
  int          busy_run;
  logic [40:0] exp_q[$];
  logic [7:0]  tx_bytes[$];
  logic [40:0] mon_e;
  vec_t        tbl[6];

  // clock / reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // scoreboard: every accepted write must match the front of the expected queue
  always @(negedge wclk) begin
    if (resetn && load_done) done_pulses++;
    if (resetn && ram_wr && !ram_busy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h ds %0b, expected none",
                 ram_addr, ram_din, ram_ds);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {ram_addr, ram_din, ram_ds}, mon_e);
      end
    end
  end

  // random busy with runs of at most 3 cycles
  initial begin
    busy_run = 0;
    forever begin
      @(posedge wclk);
      #1;
      if (busy_rand) begin
        if (busy_run >= 3) begin
          ram_busy = 1'b0;
          busy_run = 0;
        end else begin
          ram_busy = ($urandom_range(0, 3) == 0);
          busy_run = ram_busy ? busy_run + 1 : 0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rom_do       = b;
    rom_do_valid = 1'b1;
    tick();
    rom_do_valid = 1'b0;
    rom_do       = 8'h00;
  endtask

  task automatic start_load(input logic [23:0] mask);
    rom_mask    = mask;
    rom_loading = 1'b1;
    tick();
  endtask

  task automatic end_load();
    rom_loading = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge wclk);
      if (load_done) found = 1'b1;
    end
    check({name, "_done"}, 64'(found), 64'd1);
    if (found) begin
      @(negedge wclk);
      check({name, "_done_width"}, 64'(load_done), 64'd0);
    end
  endtask

  // reference model: little-endian pairs from the accepted prefix of the stream
  task automatic model_words(input logic [23:0] mask, input int limit_words);
    int          acc;
    logic [22:0] a;
    acc = (tx_bytes.size() > int'(mask) + 1) ? int'(mask) + 1 : tx_bytes.size();
    for (int i = 0; i < acc && (i / 2) < limit_words; i += 2) begin
      a = TB_BASE + 23'(i);
      if (i + 1 < acc) exp_q.push_back({a, tx_bytes[i+1], tx_bytes[i], 2'b11});
      else             exp_q.push_back({a, 8'h00, tx_bytes[i], 2'b01});
    end
  endtask

  task automatic do_load(input string name, input logic [23:0] mask, input bit rnd_gap,
                         input logic [23:0] exp_count, input logic exp_ovs);
    model_words(mask, 1 << 20);
    start_load(mask);
    check({name, "_count_clr"}, 64'(byte_count), 64'd0);
    foreach (tx_bytes[i]) begin
      send_byte(tx_bytes[i]);
      if (rnd_gap) tick($urandom_range(1, 3));
    end
    end_load();
    wait_done(name);
    check({name, "_count"}, 64'(byte_count), 64'(exp_count));
    check({name, "_oversize"}, 64'(oversize), 64'(exp_ovs));
    check({name, "_overflow"}, 64'(overflow), 64'd0);
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          n;
    int          d0;
    logic [23:0] mask;
    logic [23:0] ecount;

    tbl[0] = '{8, 24'hFFFFFF, 8'h00, 24'd8, 1'b0};
    tbl[1] = '{5, 24'hFFFFFF, 8'hA0, 24'd5, 1'b0};
    tbl[2] = '{6, 24'd3,      8'h10, 24'd4, 1'b1};
    tbl[3] = '{1, 24'hFFFFFF, 8'h5A, 24'd1, 1'b0};
    tbl[4] = '{7, 24'd4,      8'hF0, 24'd5, 1'b1};
    tbl[5] = '{0, 24'hFFFFFF, 8'h00, 24'd0, 1'b0};

    vectors      = 0;
    miscompares  = 0;
    done_pulses  = 0;
    busy_rand    = 1'b0;
    resetn       = 1'b0;
    rom_loading  = 1'b0;
    rom_do       = 8'h00;
    rom_do_valid = 1'b0;
    rom_mask     = 24'hFFFFFF;
    ram_busy     = 1'b0;

    tick(2);
    check("rst_wr", 64'(ram_wr), 64'd0);
    check("rst_ds", 64'(ram_ds), 64'd3);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    resetn = 1'b1;
    tick(2);

    // table-driven loads, port always free, bytes back to back
    foreach (tbl[t]) begin
      tx_bytes.delete();
      for (int i = 0; i < tbl[t].n; i++) tx_bytes.push_back(tbl[t].dbase + 8'(i));
      do_load($sformatf("tbl%0d", t), tbl[t].mask, 1'b0, tbl[t].exp_count, tbl[t].exp_ovs);
    end

    // write port presents a new word the cycle after its odd byte; then async reset
    ram_busy = 1'b1;
    start_load(24'hFFFFFF);
    send_byte(8'h11);
    send_byte(8'h22);
    check("lat_wr", 64'(ram_wr), 64'd1);
    check("lat_addr", 64'(ram_addr), 64'(TB_BASE));
    check("lat_data", 64'(ram_din), 64'h2211);
    check("lat_ds", 64'(ram_ds), 64'd3);
    send_byte(8'h33);
    send_byte(8'h44);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_wr", 64'(ram_wr), 64'd0);
    check("arst_addr", 64'(ram_addr), 64'd0);
    check("arst_din", 64'(ram_din), 64'd0);
    check("arst_ds", 64'(ram_ds), 64'd3);
    check("arst_count", 64'(byte_count), 64'd0);
    check("arst_flags", 64'({load_done, overflow, oversize}), 64'd0);
    rom_loading = 1'b0;
    tick(2);
    resetn   = 1'b1;
    ram_busy = 1'b0;
    tick();
    tx_bytes.delete();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'h80 + 8'(i));
    do_load("post_rst", 24'hFFFFFF, 1'b0, 24'd4, 1'b0);

    // overflow: busy for 40 cycles while 40 bytes stream in; 9 words fit
    tx_bytes.delete();
    for (int i = 0; i < 40; i++) tx_bytes.push_back(8'h40 + 8'(i));
    model_words(24'hFFFFFF, DEPTH + 1);
    ram_busy = 1'b1;
    start_load(24'hFFFFFF);
    for (int i = 0; i < 18; i++) send_byte(tx_bytes[i]);
    check("ovf_before", 64'(overflow), 64'd0);
    for (int i = 18; i < 20; i++) send_byte(tx_bytes[i]);
    check("ovf_after", 64'(overflow), 64'd1);
    for (int i = 20; i < 40; i++) send_byte(tx_bytes[i]);
    ram_busy = 1'b0;
    end_load();
    wait_done("ovf");
    check("ovf_count", 64'(byte_count), 64'd40);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_pending", 64'(exp_q.size()), 64'd0);

    // re-raise rom_loading during FLUSH: pending words dropped, no done pulse
    ram_busy = 1'b1;
    start_load(24'hFFFFFF);
    for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
    end_load();
    tick(2);
    check("abort_in_flush", 64'(fsm_state), 64'(ST_FLUSH));
    d0 = done_pulses;
    rom_loading = 1'b1;
    tick();
    check("abort_wr", 64'(ram_wr), 64'd0);
    check("abort_count", 64'(byte_count), 64'd0);
    check("abort_state", 64'(fsm_state), 64'(ST_LOAD));
    ram_busy = 1'b0;
    tx_bytes.delete();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'hD0 + 8'(i));
    model_words(24'hFFFFFF, 1 << 20);
    foreach (tx_bytes[i]) send_byte(tx_bytes[i]);
    end_load();
    wait_done("abort_new");
    check("abort_done_cnt", 64'(done_pulses - d0), 64'd1);
    check("abort_new_count", 64'(byte_count), 64'd4);
    check("abort_pending", 64'(exp_q.size()), 64'd0);

    // randomized loads with random busy and input gaps
    busy_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      n    = $urandom_range(0, 40);
      mask = ($urandom_range(0, 2) == 0) ? 24'($urandom_range(0, 20)) : 24'hFFFFFF;
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      ecount = (n > int'(mask) + 1) ? mask + 24'd1 : 24'(n);
      do_load($sformatf("rnd%0d", r), mask, 1'b1, ecount, 1'(n > int'(mask) + 1));
    end
    busy_rand = 1'b0;
    tick();
    ram_busy = 1'b0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
